// File: rtl/timer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : timer_scheduler
// Description : Host-programmed delay sequencer. The host stages the low 24
//               bits of a delay, pushes full 48-bit delays into a small FIFO,
//               then starts a run. Each entry is loaded into an external
//               48-bit down-counter; when the counter reports zero a step
//               pulse is issued and the next entry is loaded. A done pulse
//               marks the end of the queue.
//
// Ports       : clk        in   system clock, rising edge
//               rst        in   asynchronous active-high reset
//               cs         in   host command strobe
//               op   [3:0] in   0=stage lo24, 1=push, 2=start, 3=abort
//               addr [7:0] in   high byte of a 24-bit half-word
//               data_in[15:0] in low 16 bits of a 24-bit half-word
//               timer_load out  one-cycle counter load strobe
//               timer_data[47:0] out counter load value (held between loads)
//               timer_end  in   counter-at-zero flag
//               busy       out  a run is in progress
//               step       out  one-cycle pulse per expired delay
//               done       out  one-cycle pulse when the queue is exhausted
//               full       out  queue holds DEPTH entries
//               overflow   out  sticky: a push was dropped
//
// Parameters  : DEPTH - queue depth, power of 2 in 2..16
// Macro       : TIMER_SCHED_REPEAT_EN - each popped entry is re-pushed to the
//               tail so the queue loops until abort; done never pulses.
//
// Revision    : 1.0 - initial release
// ============================================================================
module timer_scheduler #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic [3:0]  op,
    input  logic [7:0]  addr,
    input  logic [15:0] data_in,
    output logic        timer_load,
    output logic [47:0] timer_data,
    input  logic        timer_end,
    output logic        busy,
    output logic        step,
    output logic        done,
    output logic        full,
    output logic        overflow
);

    localparam int c_AW = $clog2(DEPTH);

    localparam logic [c_AW:0]   c_FULL_CNT = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE  = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
    localparam logic [c_AW-1:0] c_PTR_TWO  = c_AW'(2);

    localparam logic [3:0] c_OP_LO24  = 4'h0;
    localparam logic [3:0] c_OP_PUSH  = 4'h1;
    localparam logic [3:0] c_OP_START = 4'h2;
    localparam logic [3:0] c_OP_ABORT = 4'h3;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_ARM  = 2'd2;
    localparam logic [1:0] c_ST_WAIT = 2'd3;

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [47:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW:0]   r_count;
    logic [23:0]     r_lo24;
    logic [47:0]     r_timer_data;
    logic            r_step;
    logic            r_done;
    logic            r_overflow;

    // ------------------------------------------------------------------
    // Command decode (only one opcode per cycle, so commands are exclusive)
    // ------------------------------------------------------------------
    logic        w_cmd_lo24;
    logic        w_cmd_push;
    logic        w_cmd_start;
    logic        w_cmd_abort;
    logic        w_full;
    logic        w_push_ok;
    logic        w_push_drop;
    logic [47:0] w_push_data;
    logic [47:0] w_head;

    assign w_cmd_lo24  = cs && (op == c_OP_LO24);
    assign w_cmd_push  = cs && (op == c_OP_PUSH);
    assign w_cmd_start = cs && (op == c_OP_START);
    assign w_cmd_abort = cs && (op == c_OP_ABORT);

    assign w_full      = (r_count == c_FULL_CNT);
    assign w_push_ok   = w_cmd_push && !w_full;
    assign w_push_drop = w_cmd_push && w_full;
    assign w_push_data = {addr, data_in, r_lo24};
    assign w_head      = r_mem[r_rd_ptr];

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    logic [1:0] w_state_nxt;
    logic       w_pop;
    logic       w_step;
    logic       w_done;
    logic       w_has_next;

    // A push landing in the same cycle as the expiry still counts as a
    // pending entry, so the run continues instead of finishing.
    assign w_has_next = (r_count != '0) || w_push_ok;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_step      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_cmd_start && (r_count != '0)) begin
                    w_state_nxt = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                w_pop       = 1'b1;
                w_state_nxt = c_ST_ARM;
            end
            c_ST_ARM: begin
                // Counter has only just been loaded; its zero flag is stale.
                w_state_nxt = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (timer_end) begin
                    w_step = 1'b1;
                    if (w_has_next) begin
                        w_state_nxt = c_ST_LOAD;
                    end else begin
                        w_done      = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
        if (w_cmd_abort) begin
            w_state_nxt = c_ST_IDLE;
            w_pop       = 1'b0;
            w_step      = 1'b0;
            w_done      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Queue write-port selection
    // ------------------------------------------------------------------
    logic        w_wr0_en;
    logic [47:0] w_wr0_data;
    logic        w_wr1_en;
    logic        w_cnt_dec;

`ifdef TIMER_SCHED_REPEAT_EN
    // The popped head is recycled to the tail; a host push in the same
    // cycle lands one slot behind it. Pop+recycle leaves the count alone.
    assign w_wr0_en   = w_pop || w_push_ok;
    assign w_wr0_data = w_pop ? w_head : w_push_data;
    assign w_wr1_en   = w_pop && w_push_ok;
    assign w_cnt_dec  = 1'b0;
`else
    assign w_wr0_en   = w_push_ok;
    assign w_wr0_data = w_push_data;
    assign w_wr1_en   = 1'b0;
    assign w_cnt_dec  = w_pop;
`endif

    always_ff @(posedge clk) begin
        if (w_wr0_en) begin
            r_mem[r_wr_ptr] <= w_wr0_data;
        end
        if (w_wr1_en) begin
            r_mem[r_wr_ptr + c_PTR_ONE] <= w_push_data;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, count, staging register, output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_lo24       <= '0;
            r_timer_data <= '0;
            r_step       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_step <= w_step;
            r_done <= w_done;

            if (timer_load) begin
                r_timer_data <= w_head;
            end

            // A dropped push in the same cycle outranks the clear on start.
            if (w_push_drop) begin
                r_overflow <= 1'b1;
            end else if (w_cmd_start) begin
                r_overflow <= 1'b0;
            end

            if (w_cmd_abort) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
                r_lo24   <= '0;
            end else begin
                if (w_cmd_lo24) begin
                    r_lo24 <= {addr, data_in};
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                if (w_wr1_en) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_TWO;
                end else if (w_wr0_en) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_push_ok && !w_cnt_dec) begin
                    r_count <= r_count + c_CNT_ONE;
                end else if (!w_push_ok && w_cnt_dec) begin
                    r_count <= r_count - c_CNT_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign timer_load = (r_state == c_ST_LOAD);
    assign timer_data = timer_load ? w_head : r_timer_data;
    assign busy       = (r_state != c_ST_IDLE);
    assign step       = r_step;
    assign done       = r_done;
    assign full       = w_full;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_timer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_scheduler
// Description : Self-checking bench for timer_scheduler. A table of per-cycle
//               input/expected-output records covers the default build;
//               hand-written sequences cover asynchronous reset and the
//               TIMER_SCHED_REPEAT_EN looping mode. timer_end is driven
//               directly from the table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_scheduler;

    localparam logic [3:0] OP_LO    = 4'h0;
    localparam logic [3:0] OP_PUSH  = 4'h1;
    localparam logic [3:0] OP_START = 4'h2;
    localparam logic [3:0] OP_ABORT = 4'h3;

    // Flag vector order: {timer_load, busy, step, done, full, overflow}
    localparam logic [5:0] F_LOAD = 6'b100000;
    localparam logic [5:0] F_BUSY = 6'b010000;
    localparam logic [5:0] F_STEP = 6'b001000;
    localparam logic [5:0] F_DONE = 6'b000100;
    localparam logic [5:0] F_FULL = 6'b000010;
    localparam logic [5:0] F_OVF  = 6'b000001;
    localparam logic [5:0] F_NONE = 6'b000000;

    logic        clk;
    logic        rst;
    logic        cs;
    logic [3:0]  op;
    logic [7:0]  addr;
    logic [15:0] data_in;
    logic        timer_load;
    logic [47:0] timer_data;
    logic        timer_end;
    logic        busy;
    logic        step;
    logic        done;
    logic        full;
    logic        overflow;

    timer_scheduler #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cs         (cs),
        .op         (op),
        .addr       (addr),
        .data_in    (data_in),
        .timer_load (timer_load),
        .timer_data (timer_data),
        .timer_end  (timer_end),
        .busy       (busy),
        .step       (step),
        .done       (done),
        .full       (full),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cs;
        logic [3:0]  op;
        logic [7:0]  addr;
        logic [15:0] din;
        logic        tend;
        logic [5:0]  exp_f;
        logic [47:0] exp_d;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    int          rp_steps, rp_dones, rp_loads, rp_order_err, rp_after;
    logic [47:0] rp_expect;
    logic        quiet_seen;

    function automatic logic [5:0] flags();
        return {timer_load, busy, step, done, full, overflow};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic c, input logic [3:0] o, input logic [7:0] a,
                       input logic [15:0] d, input logic te,
                       input logic [5:0] f, input logic [47:0] x);
        vec_t v;
        v.cs = c; v.op = o; v.addr = a; v.din = d; v.tend = te;
        v.exp_f = f; v.exp_d = x;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic c, input logic [3:0] o, input logic [15:0] d, input logic te);
        cs = c; op = o; addr = 8'h00; data_in = d; timer_end = te;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        drive(1'b0, OP_LO, 16'h0, 1'b0);

        // ---------------- Scenario A: two entries, normal run -------------
        add(1, OP_LO,    0, 16'h0005, 0, F_NONE, 48'h0);
        add(1, OP_PUSH,  0, 16'h0000, 0, F_NONE, 48'h0);
        add(1, OP_LO,    0, 16'h0003, 0, F_NONE, 48'h0);
        add(1, OP_PUSH,  0, 16'h0000, 0, F_NONE, 48'h0);
        add(1, OP_START, 0, 16'h0000, 0, F_NONE, 48'h0);
        add(0, OP_LO,    0, 16'h0000, 0, F_LOAD | F_BUSY, 48'h5);
        add(0, OP_LO,    0, 16'h0000, 1, F_BUSY, 48'h5);          // ARM ignores timer_end
        add(0, OP_LO,    0, 16'h0000, 0, F_BUSY, 48'h5);
        add(0, OP_LO,    0, 16'h0000, 0, F_BUSY, 48'h5);
        add(0, OP_LO,    0, 16'h0000, 1, F_BUSY, 48'h5);
        add(0, OP_LO,    0, 16'h0000, 0, F_LOAD | F_BUSY | F_STEP, 48'h3);
        add(0, OP_LO,    0, 16'h0000, 0, F_BUSY, 48'h3);
        add(0, OP_LO,    0, 16'h0000, 1, F_BUSY, 48'h3);
        add(0, OP_LO,    0, 16'h0000, 0, F_STEP | F_DONE, 48'h3);
        add(1, 4'h7,     0, 16'h0000, 0, F_NONE, 48'h3);          // undefined op
        add(0, OP_PUSH,  0, 16'h0005, 0, F_NONE, 48'h3);          // cs low
        add(1, OP_START, 0, 16'h0000, 0, F_NONE, 48'h3);          // empty queue
        add(0, OP_LO,    0, 16'h0000, 0, F_NONE, 48'h3);

        // ---------------- Scenario B: DEPTH+1 pushes ----------------------
        add(1, OP_LO,    0, 16'h0011, 0, F_NONE, 48'h3);
        add(1, OP_PUSH,  0, 16'h0001, 0, F_NONE, 48'h3);
        add(1, OP_PUSH,  0, 16'h0002, 0, F_NONE, 48'h3);
        add(1, OP_PUSH,  0, 16'h0003, 0, F_NONE, 48'h3);
        add(1, OP_PUSH,  0, 16'h0004, 0, F_NONE, 48'h3);
        add(1, OP_PUSH,  0, 16'h0005, 0, F_FULL, 48'h3);
        add(1, OP_START, 0, 16'h0000, 0, F_FULL | F_OVF, 48'h3);
        add(0, OP_LO,    0, 16'h0000, 0, F_LOAD | F_BUSY | F_FULL, 48'h000001_000011);
        add(0, OP_LO,    0, 16'h0000, 1, F_BUSY, 48'h000001_000011);
        add(0, OP_LO,    0, 16'h0000, 1, F_BUSY, 48'h000001_000011);
        add(0, OP_LO,    0, 16'h0000, 1, F_LOAD | F_BUSY | F_STEP, 48'h000002_000011);
        add(0, OP_LO,    0, 16'h0000, 1, F_BUSY, 48'h000002_000011);
        add(0, OP_LO,    0, 16'h0000, 1, F_BUSY, 48'h000002_000011);
        add(0, OP_LO,    0, 16'h0000, 1, F_LOAD | F_BUSY | F_STEP, 48'h000003_000011);
        add(0, OP_LO,    0, 16'h0000, 1, F_BUSY, 48'h000003_000011);
        add(0, OP_LO,    0, 16'h0000, 1, F_BUSY, 48'h000003_000011);
        add(0, OP_LO,    0, 16'h0000, 1, F_LOAD | F_BUSY | F_STEP, 48'h000004_000011);
        add(0, OP_LO,    0, 16'h0000, 1, F_BUSY, 48'h000004_000011);
        add(0, OP_LO,    0, 16'h0000, 1, F_BUSY, 48'h000004_000011);
        add(0, OP_LO,    0, 16'h0000, 0, F_STEP | F_DONE, 48'h000004_000011);
        add(0, OP_LO,    0, 16'h0000, 0, F_NONE, 48'h000004_000011);

        // ---------------- Scenario C: abort in WAIT -----------------------
        add(1, OP_PUSH,  0, 16'h0007, 0, F_NONE, 48'h000004_000011);
        add(1, OP_PUSH,  0, 16'h0008, 0, F_NONE, 48'h000004_000011);
        add(1, OP_PUSH,  0, 16'h0009, 0, F_NONE, 48'h000004_000011);
        add(1, OP_START, 0, 16'h0000, 0, F_NONE, 48'h000004_000011);
        add(0, OP_LO,    0, 16'h0000, 0, F_LOAD | F_BUSY, 48'h000007_000011);
        add(0, OP_LO,    0, 16'h0000, 0, F_BUSY, 48'h000007_000011);
        add(0, OP_LO,    0, 16'h0000, 0, F_BUSY, 48'h000007_000011);
        add(1, OP_ABORT, 0, 16'h0000, 1, F_BUSY, 48'h000007_000011);
        add(1, OP_START, 0, 16'h0000, 0, F_NONE, 48'h000007_000011);
        add(0, OP_LO,    0, 16'h0000, 0, F_NONE, 48'h000007_000011);
        add(0, OP_LO,    0, 16'h0000, 0, F_NONE, 48'h000007_000011);

        // ---------------- Scenario D: pushes while running ----------------
        // Staging register was cleared by abort, so lo24 is zero here.
        add(1, OP_PUSH,  0, 16'h0021, 0, F_NONE, 48'h000007_000011);
        add(1, OP_PUSH,  0, 16'h0022, 0, F_NONE, 48'h000007_000011);
        add(1, OP_START, 0, 16'h0000, 0, F_NONE, 48'h000007_000011);
        add(0, OP_LO,    0, 16'h0000, 0, F_LOAD | F_BUSY, 48'h000021_000000);
        add(0, OP_LO,    0, 16'h0000, 0, F_BUSY, 48'h000021_000000);
        add(1, OP_PUSH,  0, 16'h0023, 0, F_BUSY, 48'h000021_000000);   // push in WAIT
        add(0, OP_LO,    0, 16'h0000, 1, F_BUSY, 48'h000021_000000);
        add(1, OP_PUSH,  0, 16'h0024, 0, F_LOAD | F_BUSY | F_STEP, 48'h000022_000000); // push+pop
        add(0, OP_LO,    0, 16'h0000, 0, F_BUSY, 48'h000022_000000);
        add(0, OP_LO,    0, 16'h0000, 1, F_BUSY, 48'h000022_000000);
        add(0, OP_LO,    0, 16'h0000, 0, F_LOAD | F_BUSY | F_STEP, 48'h000023_000000);
        add(0, OP_LO,    0, 16'h0000, 0, F_BUSY, 48'h000023_000000);
        add(0, OP_LO,    0, 16'h0000, 1, F_BUSY, 48'h000023_000000);
        add(0, OP_LO,    0, 16'h0000, 0, F_LOAD | F_BUSY | F_STEP, 48'h000024_000000);
        add(0, OP_LO,    0, 16'h0000, 0, F_BUSY, 48'h000024_000000);
        add(0, OP_LO,    0, 16'h0000, 1, F_BUSY, 48'h000024_000000);
        add(0, OP_LO,    0, 16'h0000, 0, F_STEP | F_DONE, 48'h000024_000000);
        add(0, OP_LO,    0, 16'h0000, 0, F_NONE, 48'h000024_000000);

        // ---------------- Reset state --------------------------------------
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", 64'(flags()), 64'(F_NONE));
        check("reset_data", 64'(timer_data), 64'h0);
        @(negedge clk);
        rst = 1'b0;

`ifdef TIMER_SCHED_REPEAT_EN
        // ---------------- Looping mode -------------------------------------
        @(negedge clk); drive(1'b1, OP_PUSH, 16'h0041, 1'b0);
        @(negedge clk); drive(1'b1, OP_PUSH, 16'h0042, 1'b0);
        @(negedge clk); drive(1'b1, OP_START, 16'h0000, 1'b0);
        @(negedge clk); drive(1'b0, OP_LO, 16'h0000, 1'b1);
        rp_steps = 0; rp_dones = 0; rp_loads = 0; rp_order_err = 0;
        rp_expect = 48'h000041_000000;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (step) rp_steps++;
            if (done) rp_dones++;
            if (timer_load) begin
                rp_loads++;
                if (timer_data !== rp_expect) rp_order_err++;
                rp_expect = (rp_expect == 48'h000041_000000) ? 48'h000042_000000
                                                             : 48'h000041_000000;
            end
            @(negedge clk);
        end
        check("repeat_steps_gt4", 64'(rp_steps > 4), 64'd1);
        check("repeat_loads_gt4", 64'(rp_loads > 4), 64'd1);
        check("repeat_no_done", 64'(rp_dones), 64'd0);
        check("repeat_order", 64'(rp_order_err), 64'd0);
        drive(1'b1, OP_ABORT, 16'h0000, 1'b1);
        @(negedge clk); drive(1'b0, OP_LO, 16'h0000, 1'b1);
        rp_after = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (step || timer_load || busy || done) rp_after++;
            @(negedge clk);
        end
        check("repeat_abort_stops", 64'(rp_after), 64'd0);
`else
        // ---------------- Table-driven run ---------------------------------
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            cs = vecs[i].cs; op = vecs[i].op; addr = vecs[i].addr;
            data_in = vecs[i].din; timer_end = vecs[i].tend;
            #1;
            check($sformatf("vec%0d_flags", i), 64'(flags()), 64'(vecs[i].exp_f));
            check($sformatf("vec%0d_data", i), 64'(timer_data), 64'(vecs[i].exp_d));
        end
`endif

        // ---------------- Async reset during ARM ---------------------------
        @(negedge clk); drive(1'b1, OP_PUSH, 16'h0031, 1'b0);
        @(negedge clk); drive(1'b1, OP_START, 16'h0000, 1'b0);
        @(negedge clk); drive(1'b0, OP_LO, 16'h0000, 1'b0);   // LOAD
        @(negedge clk);                                        // ARM
        #1;
        check("arm_reached", 64'({timer_load, busy}), 64'(2'b01));
        rst = 1'b1;
        #1;
        check("rst_async_flags", 64'(flags()), 64'(F_NONE));
        check("rst_async_data", 64'(timer_data), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        timer_end = 1'b1;
        @(negedge clk); drive(1'b1, OP_START, 16'h0000, 1'b1);
        @(negedge clk); drive(1'b0, OP_LO, 16'h0000, 1'b1);
        quiet_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            quiet_seen = quiet_seen | timer_load | step | done | busy;
            @(negedge clk);
        end
        check("post_rst_quiet", 64'(quiet_seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
